// File: rtl/led_blink_pkg.sv
// Shared encodings for the LED blinker bank: configuration modes and
// per-channel state, plus small state-decode helpers.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_ON       = 3'd1,
        ST_BLINK_HI = 3'd2,
        ST_BLINK_LO = 3'd3,
        ST_BURST_HI = 3'd4,
        ST_BURST_LO = 3'd5,
        ST_DONE     = 3'd6
    } chan_state_e;

    function automatic logic state_led(input chan_state_e s);
        return (s == ST_ON) || (s == ST_BLINK_HI) || (s == ST_BURST_HI);
    endfunction

    function automatic logic state_busy(input chan_state_e s);
        return (s == ST_BURST_HI) || (s == ST_BURST_LO);
    endfunction

    function automatic logic state_blink(input chan_state_e s);
        return (s == ST_BLINK_HI) || (s == ST_BLINK_LO);
    endfunction

    // Only blinking and bursting channels advance their phase counter on a tick.
    function automatic logic state_timed(input chan_state_e s);
        return state_blink(s) || state_busy(s);
    endfunction

endpackage

// File: rtl/led_blink_bank_if.sv
// Configuration bus of the blinker bank: one-cycle write strobe with
// channel address and fields, plus the phase-realign strobe.
interface led_blink_bank_if #(
    parameter int CHANNELS = 10,
    parameter int PERIOD_W = 12,
    parameter int CNT_W    = 8
);
    import led_blink_pkg::*;

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                CFG_WE;
    logic [CH_W-1:0]     CFG_CH;
    mode_e               CFG_MODE;
    logic [PERIOD_W-1:0] CFG_HALF;
    logic [CNT_W-1:0]    CFG_COUNT;
    logic                SYNC;

    modport master (
        output CFG_WE,
        output CFG_CH,
        output CFG_MODE,
        output CFG_HALF,
        output CFG_COUNT,
        output SYNC
    );

    modport slave (
        input CFG_WE,
        input CFG_CH,
        input CFG_MODE,
        input CFG_HALF,
        input CFG_COUNT,
        input SYNC
    );

endinterface

// File: rtl/led_blink_channel.sv
// One LED channel: OFF/ON/BLINK/BURST state machine with its phase counter
// and remaining-pulse counter; LED and BUSY leave the block registered.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int PERIOD_W = 12,
    parameter int CNT_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic                sync_i,
    input  logic                we_i,
    input  mode_e               mode_i,
    input  logic [PERIOD_W-1:0] half_i,
    input  logic [CNT_W-1:0]    count_i,
    output logic                led_o,
    output logic                busy_o
);

    chan_state_e         state_q, state_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                phase_end;

    // half_q is never 0, so half_q-1 cannot underflow and the counter never wraps.
    assign phase_end = (phase_q == (half_q - PERIOD_W'(1)));

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        phase_d  = phase_q;
        remain_d = remain_q;

        if (we_i) begin
            phase_d  = '0;
            half_d   = (half_i == '0) ? PERIOD_W'(1) : half_i;
            remain_d = count_i;
            case (mode_i)
                MODE_OFF:   state_d = ST_OFF;
                MODE_ON:    state_d = ST_ON;
                MODE_BLINK: state_d = ST_BLINK_HI;
                MODE_BURST: state_d = (count_i == '0) ? ST_OFF : ST_BURST_HI;
                default:    state_d = ST_OFF;
            endcase
        end else if (sync_i && state_blink(state_q)) begin
            phase_d = '0;
            state_d = ST_BLINK_HI;
        end else if (tick_i && state_timed(state_q)) begin
            if (phase_end) begin
                phase_d = '0;
                case (state_q)
                    ST_BLINK_HI: state_d = ST_BLINK_LO;
                    ST_BLINK_LO: state_d = ST_BLINK_HI;
                    ST_BURST_HI: begin
                        remain_d = remain_q - CNT_W'(1);
                        state_d  = (remain_q == CNT_W'(1)) ? ST_DONE : ST_BURST_LO;
                    end
                    ST_BURST_LO: state_d = ST_BURST_HI;
                    default:     state_d = state_q;
                endcase
            end else begin
                phase_d = phase_q + PERIOD_W'(1);
            end
        end

        led_d  = state_led(state_d);
        busy_d = state_busy(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_OFF;
            half_q   <= PERIOD_W'(1);
            phase_q  <= '0;
            remain_q <= '0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_blink_bank.sv
// Bank of independent LED blinkers sharing one prescaled time base;
// the prescaler and the write-address decode live here.
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 10,
    parameter int PERIOD_W = 12,
    parameter int CNT_W    = 8
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    led_blink_bank_if.slave     cfg,
    output logic                TICK,
    output logic [CHANNELS-1:0] LED,
    output logic [CHANNELS-1:0] BUSY
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = $clog2(DIV);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d;

    // TICK is registered from the next count, so it is high exactly while ps_q == DIV-1.
    always_comb begin
        ps_d = ps_q + PS_W'(1);
        if (cfg.SYNC || (ps_q == PS_LAST)) begin
            ps_d = '0;
        end
        tick_d = (ps_d == PS_LAST);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            tick_q <= tick_d;
        end
    end

    assign TICK = tick_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic we_ch;

        // Addresses at or above CHANNELS match no channel, so such writes are dropped.
        assign we_ch = cfg.CFG_WE && (cfg.CFG_CH == CH_W'(g));

        led_blink_channel #(
            .PERIOD_W (PERIOD_W),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk_i   (CLOCK_50),
            .rst_ni  (RESET_N),
            .tick_i  (tick_q),
            .sync_i  (cfg.SYNC),
            .we_i    (we_ch),
            .mode_i  (cfg.CFG_MODE),
            .half_i  (cfg.CFG_HALF),
            .count_i (cfg.CFG_COUNT),
            .led_o   (LED[g]),
            .busy_o  (BUSY[g])
        );
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank with DIV=10 and ten channels; inputs
// change and outputs are sampled on the falling clock edge.
module tb_led_blink_bank;
    import led_blink_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic [9:0] led;
    logic [9:0] busy;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n;

    always #5 clk = ~clk;

    led_blink_bank_if #(.CHANNELS(10), .PERIOD_W(12), .CNT_W(8)) bus ();

    led_blink_bank #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .CHANNELS (10),
        .PERIOD_W (12),
        .CNT_W    (8)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .cfg      (bus),
        .TICK     (tick),
        .LED      (led),
        .BUSY     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input mode_e mode, input int half, input int count);
        bus.CFG_WE    = 1'b1;
        bus.CFG_CH    = 4'(ch);
        bus.CFG_MODE  = mode;
        bus.CFG_HALF  = 12'(half);
        bus.CFG_COUNT = 8'(count);
        @(negedge clk);
        bus.CFG_WE    = 1'b0;
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tick !== 1'b1 && cnt < 100);
    endtask

    task automatic wait_led(input int ch, input logic val, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (led[ch] !== val && cnt < 200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CFG_WE    = 1'b0;
        bus.CFG_CH    = '0;
        bus.CFG_MODE  = MODE_OFF;
        bus.CFG_HALF  = '0;
        bus.CFG_COUNT = '0;
        bus.SYNC      = 1'b0;

        // Reset state and time base
        repeat (3) @(negedge clk);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 100);
        check_eq("first_tick_cycles", n, 10);
        check_eq("led_after_release", 32'(led), 32'h0);
        wait_tick(n);
        check_eq("tick_period", n, 10);

        // BLINK ch0 HALF=3, written on a tick cycle so phases are exact
        cfg_write(0, MODE_BLINK, 3, 0);
        check_eq("blink0_on", 32'(led[0]), 32'h1);
        check_eq("blink0_busy", 32'(busy[0]), 32'h0);
        wait_led(0, 1'b0, n);
        check_eq("blink0_first_fall", n, 30);
        wait_led(0, 1'b1, n);
        check_eq("blink0_rise", n, 30);
        wait_led(0, 1'b0, n);
        check_eq("blink0_fall", n, 30);

        // BURST ch1 HALF=2 COUNT=2
        wait_tick(n);
        cfg_write(1, MODE_BURST, 2, 2);
        check_eq("burst1_led", 32'(led[1]), 32'h1);
        check_eq("burst1_busy", 32'(busy[1]), 32'h1);
        wait_led(1, 1'b0, n);
        check_eq("burst1_hi1_len", n, 20);
        check_eq("burst1_busy_mid", 32'(busy[1]), 32'h1);
        wait_led(1, 1'b1, n);
        check_eq("burst1_lo_len", n, 20);
        wait_led(1, 1'b0, n);
        check_eq("burst1_hi2_len", n, 20);
        check_eq("burst1_busy_end", 32'(busy[1]), 32'h0);
        repeat (100) @(negedge clk);
        check_eq("burst1_done_led", 32'(led[1]), 32'h0);
        check_eq("burst1_done_busy", 32'(busy[1]), 32'h0);

        // Restart the burst, then abort it during its low phase
        wait_tick(n);
        cfg_write(1, MODE_BURST, 2, 3);
        check_eq("restart1_led", 32'(led[1]), 32'h1);
        check_eq("restart1_busy", 32'(busy[1]), 32'h1);
        wait_led(1, 1'b0, n);
        check_eq("restart1_hi_len", n, 20);
        check_eq("restart1_busy_lo", 32'(busy[1]), 32'h1);
        wait_tick(n);
        check_eq("restart1_tick_gap", n, 9);
        cfg_write(1, MODE_BURST, 1, 1);
        check_eq("abort1_led", 32'(led[1]), 32'h1);
        check_eq("abort1_busy", 32'(busy[1]), 32'h1);
        wait_led(1, 1'b0, n);
        check_eq("abort1_hi_len", n, 10);
        check_eq("abort1_busy_end", 32'(busy[1]), 32'h0);

        // SYNC: ch2 HALF=2 and ch3 HALF=5 drift, ch4 ON
        cfg_write(2, MODE_BLINK, 2, 0);
        cfg_write(3, MODE_BLINK, 5, 0);
        cfg_write(4, MODE_ON, 0, 0);
        repeat (137) @(negedge clk);
        check_eq("presync_led2", 32'(led[2]), 32'h0);
        check_eq("presync_led3", 32'(led[3]), 32'h1);
        bus.SYNC = 1'b1;
        @(negedge clk);
        bus.SYNC = 1'b0;
        check_eq("sync_led2", 32'(led[2]), 32'h1);
        check_eq("sync_led3", 32'(led[3]), 32'h1);
        check_eq("sync_led4_on", 32'(led[4]), 32'h1);
        n = 1;
        while (tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sync_to_tick", n, 10);
        wait_led(2, 1'b0, n);
        check_eq("sync_led2_fall", n, 11);
        wait_led(3, 1'b0, n);
        check_eq("sync_led3_fall", n, 30);

        // Write and SYNC together: write governs ch2, SYNC forces ch3 high
        bus.SYNC = 1'b1;
        cfg_write(2, MODE_OFF, 0, 0);
        bus.SYNC = 1'b0;
        check_eq("wsync_led2", 32'(led[2]), 32'h0);
        check_eq("wsync_led3", 32'(led[3]), 32'h1);
        check_eq("wsync_led1_done", 32'(led[1]), 32'h0);

        // HALF=0 behaves as HALF=1
        wait_tick(n);
        cfg_write(5, MODE_BLINK, 0, 0);
        check_eq("half0_on", 32'(led[5]), 32'h1);
        wait_led(5, 1'b0, n);
        check_eq("half0_fall", n, 10);
        wait_led(5, 1'b1, n);
        check_eq("half0_rise", n, 10);

        // BURST with COUNT=0 behaves as OFF
        cfg_write(6, MODE_ON, 0, 0);
        check_eq("ch6_on", 32'(led[6]), 32'h1);
        cfg_write(6, MODE_BURST, 3, 0);
        check_eq("count0_led", 32'(led[6]), 32'h0);
        check_eq("count0_busy", 32'(busy[6]), 32'h0);

        // Out-of-range channel address
        cfg_write(12, MODE_ON, 1, 0);
        check_eq("ch12_on_hi", 32'(led[9:6]), 32'h0);
        check_eq("ch12_on_busy", 32'(busy), 32'h0);
        cfg_write(12, MODE_OFF, 1, 0);
        check_eq("ch12_off_led4", 32'(led[4]), 32'h1);
        check_eq("ch12_off_hi", 32'(led[9:6]), 32'h0);

        // Asynchronous reset in the middle of a burst high phase
        wait_tick(n);
        cfg_write(1, MODE_BURST, 2, 3);
        repeat (5) @(negedge clk);
        check_eq("midburst_led1", 32'(led[1]), 32'h1);
        check_eq("midburst_busy1", 32'(busy[1]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", 32'(led), 32'h0);
        check_eq("async_rst_busy", 32'(busy), 32'h0);
        check_eq("async_rst_tick", 32'(tick), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("post_rst_led", 32'(led), 32'h0);
        check_eq("post_rst_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_bank.md
# led_blink_bank

Parametrised bank of independent LED blinkers driven by a shared prescaled time base. Each channel is runtime-configured as OFF, ON, continuous BLINK or counted BURST with its own half-period, replacing per-design hard-coded divide-and-toggle counters. It sits between board-level control logic (switch/key decoding) and the `LEDR` outputs.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 1000: time-base tick rate; `DIV = CLK_HZ/TICK_HZ`, integer, must be ≥ 2.
- `CHANNELS`, default 10: number of LED channels, 1..32.
- `PERIOD_W`, default 12: width of the half-period field, in ticks.
- `CNT_W`, default 8: width of the burst pulse count.
- `CLOCK_50` in 1: the single clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `CFG_WE` in 1: one-cycle configuration write strobe.
- `CFG_CH` in `$clog2(CHANNELS)` (minimum 1): target channel.
- `CFG_MODE` in 2: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
- `CFG_HALF` in `PERIOD_W`: half-period in ticks; 0 is treated as 1.
- `CFG_COUNT` in `CNT_W`: number of burst pulses.
- `SYNC` in 1: one-cycle phase realign strobe.
- `TICK` out 1: one-cycle time-base pulse.
- `LED` out `CHANNELS`: channel outputs, active-high.
- `BUSY` out `CHANNELS`: burst in progress.

## Operation
- **Prescaler:** counts 0..DIV-1 and wraps. `TICK` is high for the single cycle when the count equals DIV-1.
- **Per channel:** mode, half-period, phase counter and remaining-pulse register.
- **Write**, `CFG_WE` with `CFG_CH` < `CHANNELS`:
  - The addressed channel latches mode, half-period and count.
  - Its phase counter clears.
  - OFF gives LED 0. ON, BLINK and BURST give LED 1.
  - BURST with `CFG_COUNT` = 0 behaves as OFF.
  - `CFG_CH` ≥ `CHANNELS`: the write is ignored.
- **Phase advance:** on `TICK`, BLINK and BURST channels increment the phase counter. When it equals half-1, the counter wraps to 0 and LED toggles.
- **BURST:**
  - `BUSY` = 1 from the write until the falling edge of the Nth high phase.
  - At that edge the LED goes to 0, `BUSY` to 0, and the channel enters DONE, which holds LED 0 until rewritten.
  - No trailing low phase.
- **Per-channel states:** OFF, ON, BLINK_HI, BLINK_LO, BURST_HI, BURST_LO, DONE.
- **SYNC:**
  - Clears the prescaler and the phase counters of all BLINK channels.
  - Forces every BLINK channel to BLINK_HI.
  - OFF, ON and BURST channels are unaffected.
- **Simultaneous events:**
  - `CFG_WE` and `SYNC` in the same cycle: the write governs the addressed channel; SYNC applies to all others.
  - `CFG_WE` and `TICK` in the same cycle: the write wins, so the phase counter is 0 afterwards.
- **Rewrite mid-burst:** aborts the burst immediately and applies the new configuration.

## Timing
- **Reset** (asynchronous, immediate):
  - `LED` = 0, `BUSY` = 0, `TICK` = 0.
  - Prescaler = 0; all channels OFF, half = 1, count = 0.
- **First tick:** first `TICK` is DIV cycles after `RESET_N` deasserts, or after a `SYNC` cycle.
- **Write latency:** `LED` and `BUSY` reflect a write on the cycle after the write edge, because all outputs are registered.
- **SYNC latency:** BLINK LEDs read 1 on the cycle after `SYNC`.
- **Phase length:**
  - The first phase after a write spans HALF ticks counted from the next `TICK`, which is (HALF-1)·DIV+1 to HALF·DIV cycles.
  - Later phases are exactly HALF·DIV cycles.
- **Counter widths:** phase counter is `PERIOD_W` bits and the remaining-pulse counter is `CNT_W` bits. Neither overflows, because the compare happens before wrap.

## Structure
- **Package `led_blink_pkg`:** mode encodings (OFF/ON/BLINK/BURST) and the channel state enumeration.
- **Sub-module `led_blink_channel`:** one channel FSM plus its counters. Instantiated `CHANNELS` times in a generate loop; inputs are tick, sync, a decoded write enable and the config fields.
- **Top level:** prescaler and write address decode live inline in the top.

## Test plan
Bench uses CLK_HZ=1000, TICK_HZ=100 (DIV=10), CHANNELS=10.
- **Reset:** release `RESET_N` → `LED`=0, `BUSY`=0; first `TICK` exactly 10 cycles later, then every 10.
- **BLINK:** write ch0 BLINK HALF=3 → LED0=1 next cycle; after the first toggle, LED0 toggles every 30 cycles (period 60).
- **BURST:** write ch1 BURST HALF=2 COUNT=2 → LED1 high 2 ticks, low 2, high 2, then 0 permanently; `BUSY1` falls with the second falling edge; a rewrite to BURST restarts it.
- **SYNC:** ch2 BLINK HALF=2 and ch3 BLINK HALF=5, run 137 cycles, pulse `SYNC` → next cycle LED2=LED3=1; next `TICK` 10 cycles after `SYNC`; ch4 ON stays 1.
- **Edge cases:**
  - HALF=0 BLINK → toggles on every `TICK`.
  - BURST COUNT=0 → LED 0, `BUSY` 0.
  - Write to `CFG_CH`=12 → no channel changes.
  - `CFG_WE` coincident with `SYNC` on ch2 → ch2 takes the new config.
- **Reset mid-burst:** assert `RESET_N` low during ch1 BURST_HI → LED1 and `BUSY1` 0 within the same cycle; after release ch1 stays OFF.
